br_pred_upd_ctrl: RTL and testbench

BR_PRED_UPD_CTRL -- requirements
Module: br_pred_upd_ctrl

---
 rtl/br_pred_upd_ctrl.sv | 94 +++++++++
 tb/tb_br_pred_upd_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/br_pred_upd_ctrl.sv
// br_pred_upd_ctrl: queues dual-lane branch commits and streams them to the counter table, with drain-then-clear sequencing
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef PredTableDepth
`define PredTableDepth 16
`endif

module br_pred_upd_ctrl #(
    parameter int ADDR = `AddrWidth,
    parameter int DEPTH = `PredTableDepth,
    parameter int QDEPTH = 4,
    localparam int PTR = $clog2(DEPTH),
    localparam int QW = $clog2(QDEPTH),
    localparam int CW = QW + 1
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            clr_req_,
    input  logic [ADDR-1:0] commit0_pc,
    input  logic [ADDR-1:0] commit1_pc,
    input  logic            commit0_,
    input  logic            commit1_,
    input  logic            result0,
    input  logic            result1,
    output logic            commit_ready_,
    output logic [ADDR-1:0] upd_pc,
    output logic            upd_result,
    output logic            upd_commit_,
    output logic            init_,
    output logic [PTR-1:0]  init_ptr,
    output logic            busy_
);
    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
    state_t          state;
    logic [ADDR-1:0] q_pc [QDEPTH];
    logic            q_res [QDEPTH];
    logic [QW-1:0]   head, tail, wptr1;
    logic [CW-1:0]   count, count_next;
    logic            acc0, acc1, pop;
    // accept/pop decisions and externally visible strobes, all derived from registered state
    always_comb begin
        commit_ready_ = !(state == RUN && count <= CW'(QDEPTH - 2));
        acc0 = !commit_ready_ && !commit0_;
        acc1 = !commit_ready_ && !commit1_;
        pop = state != CLEAR && count != '0;
        wptr1 = tail + QW'(acc0);
        count_next = count + CW'(acc0) + CW'(acc1) - CW'(pop);
        upd_commit_ = !pop;
        upd_pc = q_pc[head];
        upd_result = q_res[head];
        init_ = state != CLEAR;
        busy_ = state == RUN;
    end
    // queue storage; lane 0 lands first so it is the older entry
    always_ff @(posedge clk) begin
        if (acc0) begin
            q_pc[tail] <= commit0_pc;
            q_res[tail] <= result0;
        end
        if (acc1) begin
            q_pc[wptr1] <= commit1_pc;
            q_res[wptr1] <= result1;
        end
    end
    // pointers, occupancy and the RUN -> DRAIN -> CLEAR sequencer
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= RUN;
            head <= '0;
            tail <= '0;
            count <= '0;
            init_ptr <= '0;
        end else begin
            head <= head + QW'(pop);
            tail <= tail + QW'(acc0) + QW'(acc1);
            count <= count_next;
            case (state)
                RUN: if (!clr_req_) state <= DRAIN;
                DRAIN: if (count_next == '0) begin
                    state <= CLEAR;
                    init_ptr <= '0;
                end
                CLEAR: if (init_ptr == PTR'(DEPTH - 1)) begin
                    state <= RUN;
                    init_ptr <= '0;
                end else begin
                    init_ptr <= init_ptr + PTR'(1);
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_br_pred_upd_ctrl.sv
// tb_br_pred_upd_ctrl: directed table-driven checks of the branch-update queue and clear sequencing
module tb_br_pred_upd_ctrl;
    localparam int ADDR = 32;
    localparam int DEPTH = 16;
    localparam int QDEPTH = 4;
    localparam int PTR = $clog2(DEPTH);

    logic            clk = 0;
    logic            reset_ = 0;
    logic            clr_req_ = 1;
    logic [ADDR-1:0] commit0_pc = '0, commit1_pc = '0;
    logic            commit0_ = 1, commit1_ = 1;
    logic            result0 = 0, result1 = 0;
    logic            commit_ready_;
    logic [ADDR-1:0] upd_pc;
    logic            upd_result, upd_commit_, init_, busy_;
    logic [PTR-1:0]  init_ptr;

    int total = 0;
    int passed = 0;

    br_pred_upd_ctrl #(.ADDR(ADDR), .DEPTH(DEPTH), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset_(reset_), .clr_req_(clr_req_),
        .commit0_pc(commit0_pc), .commit1_pc(commit1_pc),
        .commit0_(commit0_), .commit1_(commit1_),
        .result0(result0), .result1(result1),
        .commit_ready_(commit_ready_), .upd_pc(upd_pc), .upd_result(upd_result),
        .upd_commit_(upd_commit_), .init_(init_), .init_ptr(init_ptr), .busy_(busy_)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c0_;
        logic [31:0] pc0;
        logic        r0;
        logic        c1_;
        logic [31:0] pc1;
        logic        r1;
        logic        clr_;
        logic        e_rdy_;
        logic        e_upd_;
        logic [31:0] e_pc;
        logic        e_res;
        logic        e_busy_;
        logic        e_init_;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic c0_, logic [31:0] pc0, logic r0, logic c1_, logic [31:0] pc1, logic r1,
                                logic clr_, logic e_rdy_, logic e_upd_, logic [31:0] e_pc, logic e_res,
                                logic e_busy_, logic e_init_);
        vec_t v;
        v.c0_ = c0_; v.pc0 = pc0; v.r0 = r0; v.c1_ = c1_; v.pc1 = pc1; v.r1 = r1; v.clr_ = clr_;
        v.e_rdy_ = e_rdy_; v.e_upd_ = e_upd_; v.e_pc = e_pc; v.e_res = e_res;
        v.e_busy_ = e_busy_; v.e_init_ = e_init_;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic drive(logic c0_, logic [31:0] pc0, logic r0, logic c1_, logic [31:0] pc1, logic r1, logic clr_);
        commit0_ = c0_; commit0_pc = pc0; result0 = r0;
        commit1_ = c1_; commit1_pc = pc1; result1 = r1;
        clr_req_ = clr_;
    endtask

    task automatic idle();
        drive(1, 0, 0, 1, 0, 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(string nm, logic rdy_, logic upd_, logic [31:0] pc, logic res, logic bsy_, logic ini_);
        chk({nm, ".commit_ready_"}, 32'(commit_ready_), 32'(rdy_));
        chk({nm, ".upd_commit_"}, 32'(upd_commit_), 32'(upd_));
        chk({nm, ".busy_"}, 32'(busy_), 32'(bsy_));
        chk({nm, ".init_"}, 32'(init_), 32'(ini_));
        if (!upd_) begin
            chk({nm, ".upd_pc"}, upd_pc, pc);
            chk({nm, ".upd_result"}, 32'(upd_result), 32'(res));
        end
    endtask

    always @(posedge clk) begin
        if (reset_ && commit_ready_ && (!commit0_ || !commit1_)) begin
            total++;
            $display("FAIL protocol: lane valid while commit_ready_ high at %0t", $time);
        end
        if (!upd_commit_ && !init_) begin
            total++;
            $display("FAIL strobe_overlap: upd_commit_=%0b init_=%0b at %0t", upd_commit_, init_, $time);
        end
    end

    initial begin
        logic [31:0] drain_pc[3];
        logic        drain_res[3];
        drain_pc = '{32'h404, 32'h408, 32'h40c};
        drain_res = '{1'b0, 1'b1, 1'b0};
        tbl[0]  = mk(0, 32'h100, 1, 1, 0, 0, 1,        0, 1, 0, 0, 1, 1);
        tbl[1]  = mk(0, 32'h200, 0, 0, 32'h204, 1, 1,  0, 0, 32'h100, 1, 1, 1);
        tbl[2]  = mk(1, 0, 0, 1, 0, 0, 1,              0, 0, 32'h200, 0, 1, 1);
        tbl[3]  = mk(1, 0, 0, 1, 0, 0, 1,              0, 0, 32'h204, 1, 1, 1);
        tbl[4]  = mk(0, 32'h300, 1, 0, 32'h304, 0, 1,  0, 1, 0, 0, 1, 1);
        tbl[5]  = mk(0, 32'h308, 1, 0, 32'h30c, 0, 1,  0, 0, 32'h300, 1, 1, 1);
        tbl[6]  = mk(1, 0, 0, 1, 0, 0, 1,              1, 0, 32'h304, 0, 1, 1);
        tbl[7]  = mk(0, 32'h310, 1, 0, 32'h314, 1, 1,  0, 0, 32'h308, 1, 1, 1);
        tbl[8]  = mk(1, 0, 0, 1, 0, 0, 1,              1, 0, 32'h30c, 0, 1, 1);
        tbl[9]  = mk(1, 0, 0, 1, 0, 0, 1,              0, 0, 32'h310, 1, 1, 1);
        tbl[10] = mk(1, 0, 0, 1, 0, 0, 1,              0, 0, 32'h314, 1, 1, 1);
        tbl[11] = mk(1, 0, 0, 1, 0, 0, 1,              0, 1, 0, 0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 1, 0, 0, 1, 1);
        chk("reset.init_ptr", 32'(init_ptr), 0);
        reset_ = 1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].c0_, tbl[i].pc0, tbl[i].r0, tbl[i].c1_, tbl[i].pc1, tbl[i].r1, tbl[i].clr_);
            chk_out($sformatf("row%0d", i), tbl[i].e_rdy_, tbl[i].e_upd_, tbl[i].e_pc, tbl[i].e_res,
                    tbl[i].e_busy_, tbl[i].e_init_);
            step();
        end

        drive(0, 32'h400, 1, 0, 32'h404, 0, 1);
        chk_out("clr.pre", 0, 1, 0, 0, 1, 1);
        step();
        drive(0, 32'h408, 1, 0, 32'h40c, 0, 0);
        chk_out("clr.req", 0, 0, 32'h400, 1, 1, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) clr_req_ = 0;
            chk_out($sformatf("drain%0d", i), 1, 0, drain_pc[i], drain_res[i], 0, 1);
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            if (i == 3) clr_req_ = 0;
            chk_out($sformatf("clear%0d", i), 1, 1, 0, 0, 0, 0);
            chk($sformatf("clear%0d.init_ptr", i), 32'(init_ptr), i);
            step();
        end
        idle();
        chk_out("clr.done", 0, 1, 0, 0, 1, 1);
        chk("clr.done.init_ptr", 32'(init_ptr), 0);
        step();
        chk_out("clr.ignored", 0, 1, 0, 0, 1, 1);

        clr_req_ = 0;
        step();
        idle();
        chk_out("rst.drain", 1, 1, 0, 0, 0, 1);
        step();
        repeat (5) step();
        chk("rst.at_ptr5", 32'(init_ptr), 5);
        chk("rst.at_ptr5.init_", 32'(init_), 0);
        #2;
        reset_ = 0;
        #1;
        chk_out("rst.async", 0, 1, 0, 0, 1, 1);
        chk("rst.async.init_ptr", 32'(init_ptr), 0);
        @(negedge clk);
        reset_ = 1;
        step();
        chk_out("rst.after", 0, 1, 0, 0, 1, 1);
        drive(0, 32'h500, 0, 1, 0, 0, 1);
        step();
        idle();
        chk_out("rst.fresh", 0, 0, 32'h500, 0, 1, 1);
        step();
        chk_out("rst.empty", 0, 1, 0, 0, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
